// File: rtl/morph_bin_arbiter_if.sv
// Requester and core-side signal bundle for morph_bin_arbiter.
//   Requester side : req0/1, mode0/1, template0/1, data0/1 in; ack0/1, out_valid0/1, out_data0/1, busy out
//   Core side      : core_in_enable, core_mode, core_template, core_in_data out; core_out_ready, core_out_data in
// The slave modport is the arbiter's view; master is the environment's view (requesters plus core).
interface morph_bin_arbiter_if #(
  parameter int unsigned window_width = 3
);
  localparam int unsigned WIN = window_width * window_width;

  logic           req0;
  logic           req1;
  logic           mode0;
  logic           mode1;
  logic [WIN-1:0] template0;
  logic [WIN-1:0] template1;
  logic [WIN-1:0] data0;
  logic [WIN-1:0] data1;
  logic           ack0;
  logic           ack1;
  logic           out_valid0;
  logic           out_valid1;
  logic           out_data0;
  logic           out_data1;
  logic           busy;
  logic           core_in_enable;
  logic           core_mode;
  logic [WIN-1:0] core_template;
  logic [WIN-1:0] core_in_data;
  logic           core_out_ready;
  logic           core_out_data;

  modport slave (
    input  req0, req1, mode0, mode1, template0, template1, data0, data1,
           core_out_ready, core_out_data,
    output ack0, ack1, out_valid0, out_valid1, out_data0, out_data1, busy,
           core_in_enable, core_mode, core_template, core_in_data
  );

  modport master (
    output req0, req1, mode0, mode1, template0, template1, data0, data1,
           core_out_ready, core_out_data,
    input  ack0, ack1, out_valid0, out_valid1, out_data0, out_data1, busy,
           core_in_enable, core_mode, core_template, core_in_data
  );
endinterface

// File: rtl/morph_bin_arbiter.sv
// Two-requester round-robin front end for a shared binary erosion/dilation core.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : morph_bin_arbiter_if.slave
//     requester N : reqN/modeN/templateN/dataN in, ackN (combinational issue strobe),
//                   out_validN/out_dataN (result strobe and bit), busy (windows in flight)
//     core        : core_in_enable (registered), core_mode/core_template/core_in_data
//                   (combinational payload), core_out_ready/core_out_data (core result LSB)
module morph_bin_arbiter #(
  parameter int unsigned window_width = 3,
  parameter int unsigned pipe_stage   = 4
) (
  input logic                clk,
  input logic                rst_n,
  morph_bin_arbiter_if.slave bus
);
  localparam int unsigned WIN = window_width * window_width;

  typedef struct packed {
    logic valid;
    logic chan;
    logic mode;
  } tag_t;

  logic           en_q;
  logic           lp_q;
  logic           mode_q;
  logic [WIN-1:0] template_q;
  logic [WIN-1:0] data_q;
  tag_t           tag_q [pipe_stage];

  logic           grant0_c;
  logic           grant1_c;
  logic           issue_c;
  logic           sel_mode_c;
  logic [WIN-1:0] sel_template_c;
  logic [WIN-1:0] sel_data_c;
  logic           core_mode_c;
  tag_t           last_c;
  logic           res_c;
  logic           busy_c;

  // Round-robin grant: with both pending, the requester that did not win last time goes.
  always_comb begin
    grant0_c       = en_q & bus.req0 & (~bus.req1 | lp_q);
    grant1_c       = en_q & bus.req1 & (~bus.req0 | ~lp_q);
    issue_c        = grant0_c | grant1_c;
    sel_mode_c     = grant1_c ? bus.mode1     : bus.mode0;
    sel_template_c = grant1_c ? bus.template1 : bus.template0;
    sel_data_c     = grant1_c ? bus.data1     : bus.data0;
  end

  // Core payload follows the winner in an issue cycle, otherwise the last issued window.
  always_comb begin
    core_mode_c       = mode_q;
    bus.core_template = template_q;
    bus.core_in_data  = data_q;
    if (issue_c) begin
      core_mode_c       = sel_mode_c;
      bus.core_template = sel_template_c;
      bus.core_in_data  = sel_data_c;
    end
  end

  // Enable, last-grant pointer and held payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      lp_q       <= 1'b1;
      mode_q     <= 1'b0;
      template_q <= '0;
      data_q     <= '0;
    end else begin
      en_q <= 1'b1;
      if (issue_c) begin
        lp_q       <= grant1_c;
        mode_q     <= sel_mode_c;
        template_q <= sel_template_c;
        data_q     <= sel_data_c;
      end
    end
  end

  // Tag pipeline tracking which requester and mode each core slot belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(pipe_stage); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: issue_c, chan: grant1_c, mode: sel_mode_c};
      for (int i = 1; i < int'(pipe_stage); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // The core's final XOR uses the live core_mode; undo it and apply the window's own mode.
  always_comb begin
    last_c = tag_q[pipe_stage-1];
    res_c  = bus.core_out_ready & (bus.core_out_data ^ core_mode_c ^ last_c.mode);
    busy_c = 1'b0;
    for (int i = 0; i < int'(pipe_stage); i++) busy_c = busy_c | tag_q[i].valid;
  end

  assign bus.ack0           = grant0_c;
  assign bus.ack1           = grant1_c;
  assign bus.core_in_enable = en_q;
  assign bus.core_mode      = core_mode_c;
  assign bus.out_valid0     = last_c.valid & ~last_c.chan;
  assign bus.out_valid1     = last_c.valid & last_c.chan;
  assign bus.out_data0      = last_c.valid & ~last_c.chan & res_c;
  assign bus.out_data1      = last_c.valid & last_c.chan & res_c;
  assign bus.busy           = busy_c;
endmodule

// File: tb/tb_morph_bin_arbiter.sv
// Directed testbench for morph_bin_arbiter with a 4-stage behavioural core model.
module tb_morph_bin_arbiter;
  localparam int unsigned WW   = 3;
  localparam int unsigned PIPE = 4;
  localparam int unsigned WIN  = WW * WW;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  morph_bin_arbiter_if #(.window_width(WW)) bus ();

  morph_bin_arbiter #(.window_width(WW), .pipe_stage(PIPE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: true result computed at issue, output XORed with issue mode and live core_mode.
  typedef struct packed {
    logic r;
    logic m;
  } core_t;
  core_t core_pipe [PIPE];
  logic  core_res;

  always_comb begin
    if (bus.core_mode) core_res = |(bus.core_in_data & bus.core_template);
    else               core_res = ((bus.core_in_data & bus.core_template) == bus.core_template);
  end

  always_ff @(posedge clk) begin
    core_pipe[0] <= '{r: core_res, m: bus.core_mode};
    for (int i = 1; i < int'(PIPE); i++) core_pipe[i] <= core_pipe[i-1];
  end

  assign bus.core_out_data = core_pipe[PIPE-1].r ^ core_pipe[PIPE-1].m ^ bus.core_mode;

  logic [6:0] obs;
  assign obs = {bus.ack0, bus.ack1, bus.out_valid0, bus.out_valid1,
                bus.out_data0, bus.out_data1, bus.busy};

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.mode0 = 1'b0; bus.mode1 = 1'b0;
    bus.template0 = '0; bus.template1 = '0;
    bus.data0 = '0; bus.data1 = '0;
    bus.core_out_ready = 1'b1;
  endtask

  // Leaves rst_n low at a falling edge; the caller releases it in its first cycle.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  // Reset values, payload isolation during reset, ack only after enable.
  task automatic test_reset();
    logic [6:0] exp [10];
    exp = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0100000,
            7'b0000001, 7'b0000001, 7'b0000001, 7'b0001011, 7'b0000000};
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    bus.req1 = 1'b1; bus.mode1 = 1'b0; bus.template1 = 9'h1FF; bus.data1 = 9'h1FF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 3) begin
        bus.data1 = ~bus.data1;
        bus.template1 = ~bus.template1;
        bus.mode1 = ~bus.mode1;
      end
      if (k == 3) begin
        rst_n = 1'b1; bus.data1 = 9'h1FF; bus.template1 = 9'h1FF; bus.mode1 = 1'b0;
      end
      if (k == 5) bus.req1 = 1'b0;
      #1;
      n_checks++;
      if (obs !== exp[k]) begin
        n_fail++; $display("FAIL reset_outputs cyc=%0d got=%b want=%b", k, obs, exp[k]);
      end
      if (k < 4) begin
        n_checks++;
        if ({bus.core_in_enable, bus.core_mode, bus.core_template, bus.core_in_data} !== '0) begin
          n_fail++;
          $display("FAIL reset_core_inputs cyc=%0d got en=%b mode=%b tmpl=%h data=%h want all 0",
                   k, bus.core_in_enable, bus.core_mode, bus.core_template, bus.core_in_data);
        end
      end
      if (k == 4) begin
        n_checks++;
        if ({bus.core_in_enable, bus.core_in_data} !== {1'b1, 9'h1FF}) begin
          n_fail++;
          $display("FAIL enable_issue got en=%b data=%h want en=1 data=1ff",
                   bus.core_in_enable, bus.core_in_data);
        end
      end
    end
  endtask

  // Single erosion window from requester 0: latency and busy window.
  task automatic test_single();
    logic [6:0] exp [7];
    exp = '{7'b0000000, 7'b1000000, 7'b0000001, 7'b0000001, 7'b0000001,
            7'b0010101, 7'b0000000};
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.template0 = 9'h1FF; bus.data0 = 9'h1FF;
      end
      if (k == 2) bus.req0 = 1'b0;
      #1;
      n_checks++;
      if (obs !== exp[k]) begin
        n_fail++; $display("FAIL single cyc=%0d got=%b want=%b", k, obs, exp[k]);
      end
    end
  endtask

  // Both requesters held: grants alternate and results come back in order.
  task automatic test_round_robin();
    logic [6:0] exp [10];
    exp = '{7'b0000000, 7'b1000000, 7'b0100001, 7'b1000001, 7'b0100001,
            7'b0010101, 7'b0001001, 7'b0010101, 7'b0001001, 7'b0000000};
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.template0 = 9'h1FF; bus.data0 = 9'h1FF;
        bus.req1 = 1'b1; bus.mode1 = 1'b0; bus.template1 = 9'h1FF; bus.data1 = 9'h1FE;
      end
      if (k == 5) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      #1;
      n_checks++;
      if (obs !== exp[k]) begin
        n_fail++; $display("FAIL round_robin cyc=%0d got=%b want=%b", k, obs, exp[k]);
      end
    end
  endtask

  // Dilation then erosion back to back: result corrected across the mode switch.
  task automatic test_back_to_back();
    logic [6:0] exp [8];
    exp = '{7'b0000000, 7'b1000000, 7'b0100001, 7'b0000001, 7'b0000001,
            7'b0010001, 7'b0001011, 7'b0000000};
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.mode0 = 1'b1; bus.template0 = 9'h1FF; bus.data0 = 9'h000;
      end
      if (k == 2) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.mode1 = 1'b0; bus.template1 = 9'h1FF; bus.data1 = 9'h1FF;
      end
      if (k == 3) bus.req1 = 1'b0;
      #1;
      n_checks++;
      if (obs !== exp[k]) begin
        n_fail++; $display("FAIL back_to_back cyc=%0d got=%b want=%b", k, obs, exp[k]);
      end
      if (k == 1 || k == 2) begin
        n_checks++;
        if (bus.core_mode !== (k == 1)) begin
          n_fail++; $display("FAIL b2b_core_mode cyc=%0d got=%b want=%b", k, bus.core_mode, k == 1);
        end
      end
    end
  endtask

  // Single-bit structuring element: hit and miss.
  task automatic test_template();
    logic [6:0] exp [8];
    exp = '{7'b0000000, 7'b1000000, 7'b1000001, 7'b0000001, 7'b0000001,
            7'b0010101, 7'b0010001, 7'b0000000};
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.template0 = 9'h010; bus.data0 = 9'h010;
      end
      if (k == 2) bus.data0 = 9'h1EF;
      if (k == 3) bus.req0 = 1'b0;
      #1;
      n_checks++;
      if (obs !== exp[k]) begin
        n_fail++; $display("FAIL template cyc=%0d got=%b want=%b", k, obs, exp[k]);
      end
    end
  endtask

  // Dropped request, payload change while waiting, core_out_ready low at result time.
  task automatic test_protocol();
    logic [6:0] exp [12];
    exp = '{7'b0000000, 7'b1000000, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0010001,
            7'b0100000, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0001001, 7'b0000000};
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.template0 = 9'h1FF; bus.data0 = 9'h1FF;
        bus.req1 = 1'b1; bus.mode1 = 1'b1; bus.template1 = 9'h1FF; bus.data1 = 9'h000;
      end
      if (k == 1) bus.data1 = 9'h0F0;
      if (k == 2) begin bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data1 = 9'h1FF; end
      if (k == 5) bus.core_out_ready = 1'b0;
      if (k == 6) begin
        bus.core_out_ready = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.data1 = 9'h000;
      end
      if (k == 7) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      #1;
      n_checks++;
      if (obs !== exp[k]) begin
        n_fail++; $display("FAIL protocol cyc=%0d got=%b want=%b", k, obs, exp[k]);
      end
      if (k == 1 || k == 2) begin
        n_checks++;
        if ({bus.core_mode, bus.core_in_data} !== {1'b0, 9'h1FF}) begin
          n_fail++;
          $display("FAIL payload_hold cyc=%0d got mode=%b data=%h want mode=0 data=1ff",
                   k, bus.core_mode, bus.core_in_data);
        end
      end
    end
  endtask

  // Reset with windows in flight: nothing emerges, pointer returns to requester 0 first.
  task automatic test_reset_midflight();
    logic [6:0] exp [13];
    exp = '{7'b0000000, 7'b1000000, 7'b0100001, 7'b1000001, 7'b0000000, 7'b0000000,
            7'b0000000, 7'b1000000, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0010101,
            7'b0000000};
    apply_reset();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 0 || k == 6) begin
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.mode0 = 1'b0; bus.template0 = 9'h1FF; bus.data0 = 9'h1FF;
        bus.req1 = 1'b1; bus.mode1 = 1'b0; bus.template1 = 9'h1FF; bus.data1 = 9'h1FF;
      end
      if (k == 4) begin rst_n = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0; end
      if (k == 8) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      #1;
      n_checks++;
      if (obs !== exp[k]) begin
        n_fail++; $display("FAIL reset_midflight cyc=%0d got=%b want=%b", k, obs, exp[k]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    idle_inputs();
    #2 rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_template();
    test_protocol();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/morph_bin_arbiter.md
MORPH_BIN_ARBITER -- requirements
Module: morph_bin_arbiter

Interface
REQ-001 Parameter window_width, default 3: window side; WIN = window_width*window_width bits per window.
REQ-002 Parameter pipe_stage, default 4: fixed latency of the shared binary erosion/dilation core, ceil(log2(WIN)).
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 reqN (N=0,1)  in  1  requester N has a window pending; held with stable payload until ackN.
REQ-006 modeN  in  1  0 erosion, 1 dilation.
REQ-007 templateN  in  WIN  structuring-element mask for requester N.
REQ-008 dataN  in  WIN  binary window for requester N.
REQ-009 ackN  out  1  combinational; high in the issue cycle of requester N.
REQ-010 out_validN  out  1  one-cycle result strobe for requester N.
REQ-011 out_dataN  out  1  result bit; 0 when out_validN is 0.
REQ-012 busy  out  1  high while any issued window is still in the pipeline.
REQ-013 core_in_enable  out  1  enable to the shared core.
REQ-014 core_mode  out  1; core_template  out  WIN; core_in_data  out  WIN  combinational payload to the core.
REQ-015 core_out_ready  in  1; core_out_data  in  1  (LSB of the core output).

Function
REQ-016 core_in_enable SHALL be a register: 0 in reset, 1 from the first clock edge after rst_n release, thereafter constant.
REQ-017 No ack SHALL assert while core_in_enable is 0.
REQ-018 Arbitration: round robin over 2 requesters; last-grant pointer lp, reset value 1 (requester 0 wins first).
REQ-019 Only reqN high: ackN=1. Both high: grant requester != lp. None: no grant.
REQ-020 lp SHALL update to the granted index on the edge ending the issue cycle; unchanged otherwise.
REQ-021 At most one ack per cycle; throughput one window per cycle, back-to-back grants permitted.
REQ-022 In an issue cycle core_mode/template/in_data SHALL equal the granted requester's modeN/templateN/dataN; in idle cycles they SHALL hold the last issued values (reset: all 0).
REQ-023 Tag pipeline: pipe_stage entries {valid, chan, mode}, shifted every clock; entry 0 loaded with {grant, index, mode} of the issue cycle, valid=0 when idle.
REQ-024 Result for a window issued in cycle t SHALL appear in cycle t+pipe_stage: out_validN=1 for exactly one cycle where N = tag chan.
REQ-025 The core applies its final mode XOR with the current core_mode; result SHALL be corrected: out_dataN = core_out_data XOR core_mode XOR tag.mode.
REQ-026 A tag reaching the output while core_out_ready=0 is a protocol error: out_valid SHALL still assert, and out_data SHALL be 0.
REQ-027 busy = OR of all tag valid bits.
REQ-028 reqN dropped without ack: no issue, no tag, lp unchanged.
REQ-029 Payload changes while reqN high and ackN low SHALL not affect core inputs or tags.

Reset
REQ-030 rst_n low SHALL asynchronously clear: core_in_enable, lp (to 1), all tags, held core payload; outputs ack0/1, out_valid0/1, out_data0/1, busy all 0 while rst_n low.
REQ-031 Reset mid-operation SHALL discard in-flight windows; no out_valid for them after release.
REQ-032 After release first ack no earlier than second rising edge (once core_in_enable=1).

Verification
REQ-033 Release reset, req0=1, mode0=0, template0=9'h1FF, data0=9'h1FF -> ack0 in first enabled cycle t; out_valid0=1, out_data0=1 at t+4; busy 1 from t+1 to t+4.
REQ-034 Both req held, erosion, data0=9'h1FF, data1=9'h1FE, template all ones -> acks alternate 0,1,0,1; out_valid alternates from t+4; out_data0=1, out_data1=0.
REQ-035 Back-to-back req0 dilation data 9'h000 then req1 erosion data 9'h1FF, template 9'h1FF -> out_data0=0 at t+4, out_data1=1 at t+5 (mode correction across switch).
REQ-036 template0=9'h010, erosion, data0=9'h010 -> out_data0=1; data0=9'h1EF -> out_data0=0.
REQ-037 Issue 3 windows, assert rst_n low two cycles later, release -> no out_valid for them; busy=0; lp=1; next grant to requester 0.
REQ-038 req1 asserted before reset release -> ack1 only once core_in_enable=1; payload toggled while waiting at rst_n low -> no core input change.
